// File: rtl/mo_pixel_serializer.sv
// Motion-object pixel serializer: latches a picture number, forms the ROM address,
// buffers one fetched ROM word and shifts it out as BPP-bit colour codes per pixel enable.
module mo_pixel_serializer #(
  parameter int BPP   = 3,
  parameter int NPIX  = 4,
  parameter int PIC_W = 8,
  parameter int LO_W  = 5
) (
  input  logic                  clk,
  input  logic                  RESETn,
  input  logic                  ce_pix,
  input  logic                  ce_pic,
  input  logic                  pic_ld,
  input  logic [PIC_W-1:0]      sr_pic,
  input  logic [LO_W-1:0]       addrlo,
  output logic [PIC_W+LO_W-1:0] rom_addr,
  input  logic                  fetch,
  input  logic [BPP*NPIX-1:0]   rom_data,
  input  logic                  matchn,
  input  logic [1:0]            mode,
  input  logic                  flip,
  output logic [BPP-1:0]        ar,
  output logic                  pix_vld,
  output logic                  buf_full,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(NPIX + 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [PIC_W-1:0]           r_picture;
  logic [BPP*NPIX-1:0]        r_buffer;
  logic                       r_buf_full;
  logic                       r_fetch_d;
  // Packed so that plane p lines up with rom_data[p*NPIX +: NPIX].
  logic [BPP-1:0][NPIX-1:0]   r_plane;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_underrun;

  logic [BPP-1:0][NPIX-1:0]   w_plane_nxt;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic [CNT_W-1:0]           w_cnt_dec;
  logic                       w_underrun_nxt;
  logic                       w_load_take;

  assign w_cnt_dec   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
  assign w_load_take = ce_pix && (mode == MODE_LOAD) && !matchn && r_buf_full;

  always_comb begin
    w_plane_nxt    = r_plane;
    w_cnt_nxt      = r_cnt;
    w_underrun_nxt = r_underrun;
    if (ce_pix) begin
      case (mode)
        MODE_HOLD: ;
        MODE_LEFT: begin
          for (int p = 0; p < BPP; p++) w_plane_nxt[p] = {r_plane[p][NPIX-2:0], 1'b0};
          w_cnt_nxt = w_cnt_dec;
        end
        MODE_RIGHT: begin
          for (int p = 0; p < BPP; p++) w_plane_nxt[p] = {1'b0, r_plane[p][NPIX-1:1]};
          w_cnt_nxt = w_cnt_dec;
        end
        default: begin
          if (matchn) begin
            w_plane_nxt = '1;
            w_cnt_nxt   = CNT_W'(NPIX);
          end else if (r_buf_full) begin
            w_plane_nxt = r_buffer;
            w_cnt_nxt   = CNT_W'(NPIX);
          end else begin
            // Nothing buffered: show transparent and flag the missed word.
            w_plane_nxt    = '1;
            w_cnt_nxt      = '0;
            w_underrun_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_picture  <= '0;
      r_buffer   <= '0;
      r_buf_full <= 1'b0;
      r_fetch_d  <= 1'b0;
      r_plane    <= '0;
      r_cnt      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_fetch_d  <= fetch;
      r_plane    <= w_plane_nxt;
      r_cnt      <= w_cnt_nxt;
      r_underrun <= w_underrun_nxt;
      if (ce_pic && pic_ld) r_picture <= sr_pic;
      if (r_fetch_d) r_buffer <= rom_data;
      // A capture on the same edge as a load keeps the buffer marked full.
      if (r_fetch_d)        r_buf_full <= 1'b1;
      else if (w_load_take) r_buf_full <= 1'b0;
    end
  end

  always_comb begin
    ar = '0;
    for (int p = 0; p < BPP; p++) ar[p] = flip ? r_plane[p][0] : r_plane[p][NPIX-1];
  end

  assign rom_addr = {r_picture, addrlo};
  assign pix_vld  = (r_cnt != '0);
  assign buf_full = r_buf_full;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_mo_pixel_serializer.sv
// Bench for mo_pixel_serializer: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against an arithmetic reference model.
module tb_mo_pixel_serializer;

  logic        clk;
  logic        RESETn;
  logic        ce_pix, ce_pic, pic_ld;
  logic [7:0]  sr_pic;
  logic [4:0]  addrlo;
  logic [12:0] rom_addr;
  logic        fetch;
  logic [11:0] rom_data;
  logic        matchn;
  logic [1:0]  mode;
  logic        flip;
  logic [2:0]  ar;
  logic        pix_vld, buf_full, underrun;

  int n_checks = 0;
  int n_errors = 0;

  mo_pixel_serializer #(.BPP(3), .NPIX(4), .PIC_W(8), .LO_W(5)) dut (
    .clk(clk), .RESETn(RESETn), .ce_pix(ce_pix), .ce_pic(ce_pic), .pic_ld(pic_ld),
    .sr_pic(sr_pic), .addrlo(addrlo), .rom_addr(rom_addr), .fetch(fetch),
    .rom_data(rom_data), .matchn(matchn), .mode(mode), .flip(flip), .ar(ar),
    .pix_vld(pix_vld), .buf_full(buf_full), .underrun(underrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Planes held as integers; shifting is multiply/divide by two, modulo 16.
  int m_pic, m_buf, m_full, m_fd, m_cnt, m_ur;
  int m_pl[3];

  always @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      m_pic = 0; m_buf = 0; m_full = 0; m_fd = 0; m_cnt = 0; m_ur = 0;
      for (int p = 0; p < 3; p++) m_pl[p] = 0;
    end else begin
      if (ce_pix) begin
        if (mode == 2'd1 || mode == 2'd2) begin
          for (int p = 0; p < 3; p++)
            m_pl[p] = (mode == 2'd1) ? (m_pl[p] * 2) % 16 : m_pl[p] / 2;
          if (m_cnt > 0) m_cnt = m_cnt - 1;
        end else if (mode == 2'd3) begin
          if (matchn) begin
            for (int p = 0; p < 3; p++) m_pl[p] = 15;
            m_cnt = 4;
          end else if (m_full != 0) begin
            for (int p = 0; p < 3; p++) m_pl[p] = (m_buf >> (4 * p)) % 16;
            m_cnt = 4;
            m_full = 0;
          end else begin
            for (int p = 0; p < 3; p++) m_pl[p] = 15;
            m_cnt = 0;
            m_ur = 1;
          end
        end
      end
      if (m_fd != 0) begin
        m_buf  = int'(rom_data);
        m_full = 1;
      end
      if (ce_pic && pic_ld) m_pic = int'(sr_pic);
      m_fd = fetch ? 1 : 0;
    end
  end

  function automatic logic [2:0] model_ar(input logic fl);
    logic [2:0] r;
    for (int p = 0; p < 3; p++) r[p] = fl ? ((m_pl[p] % 2) == 1) : ((m_pl[p] / 8) == 1);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ar",       32'(ar),       32'(model_ar(flip)));
    check("pix_vld",  32'(pix_vld),  32'(m_cnt > 0));
    check("buf_full", 32'(buf_full), 32'(m_full));
    check("underrun", 32'(underrun), 32'(m_ur));
    check("rom_addr", 32'(rom_addr), 32'(m_pic * 32 + int'(addrlo)));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    ce_pix = 1'b1; ce_pic = 1'b0; pic_ld = 1'b0; fetch = 1'b0;
    matchn = 1'b0; mode = 2'b00;
  endtask

  task automatic fetch_word(input logic [11:0] w);
    rom_data = w; fetch = 1'b1;
    step();
    fetch = 1'b0;
    step();
  endtask

  task automatic do_load(input logic mn);
    matchn = mn; mode = 2'b11;
    step();
    mode = 2'b00; matchn = 1'b0;
  endtask

  logic [2:0] exp_l [4];
  logic [2:0] exp_r [4];
  logic       exp_v [4];

  initial begin
    exp_l[0] = 3'b011; exp_l[1] = 3'b100; exp_l[2] = 3'b010; exp_l[3] = 3'b000;
    exp_r[0] = 3'b100; exp_r[1] = 3'b011; exp_r[2] = 3'b101; exp_r[3] = 3'b000;
    exp_v[0] = 1'b1;   exp_v[1] = 1'b1;   exp_v[2] = 1'b1;   exp_v[3] = 1'b0;

    RESETn = 1'b0; idle_inputs(); flip = 1'b0;
    sr_pic = 8'h00; addrlo = 5'h00; rom_data = 12'h000;
    step(); step();
    check("reset_ar", 32'(ar), 32'h0);
    check("reset_vld", 32'(pix_vld), 32'h0);
    RESETn = 1'b1;
    step();

    // Picture latch and ROM address.
    ce_pic = 1'b1; pic_ld = 1'b1; sr_pic = 8'h3C; addrlo = 5'h11;
    step();
    ce_pic = 1'b0; pic_ld = 1'b0;
    check("lit_rom_addr", 32'(rom_addr), 32'h0791);

    // Fetch pipeline: full only after the second edge.
    rom_data = 12'hA5C; fetch = 1'b1;
    step();
    fetch = 1'b0;
    check("lit_full_early", 32'(buf_full), 32'h0);
    step();
    check("lit_full", 32'(buf_full), 32'h1);

    // Load, then shift left with flip=0.
    flip = 1'b0;
    do_load(1'b0);
    check("lit_load_ar", 32'(ar), 32'h5);
    check("lit_load_vld", 32'(pix_vld), 32'h1);
    check("lit_load_empty", 32'(buf_full), 32'h0);
    for (int i = 0; i < 4; i++) begin
      mode = 2'b01;
      step();
      check("lit_left_ar", 32'(ar), 32'(exp_l[i]));
      check("lit_left_vld", 32'(pix_vld), 32'(exp_v[i]));
    end
    mode = 2'b00;

    // Same word with flip=1, shift right.
    fetch_word(12'hA5C);
    flip = 1'b1;
    do_load(1'b0);
    check("lit_flip_ar", 32'(ar), 32'h2);
    for (int i = 0; i < 4; i++) begin
      mode = 2'b10;
      step();
      check("lit_right_ar", 32'(ar), 32'(exp_r[i]));
    end
    mode = 2'b00;

    // Transparent load leaves the buffer alone; then the buffered word loads.
    fetch_word(12'hA5C);
    do_load(1'b1);
    check("lit_transp_ar", 32'(ar), 32'h7);
    check("lit_transp_full", 32'(buf_full), 32'h1);
    do_load(1'b0);
    check("lit_after_transp_ar", 32'(ar), 32'h2);

    // Underrun: load from an empty buffer.
    do_load(1'b0);
    check("lit_under_ar", 32'(ar), 32'h7);
    check("lit_under_vld", 32'(pix_vld), 32'h0);
    check("lit_under_flag", 32'(underrun), 32'h1);
    step(); step(); step();
    check("lit_under_sticky", 32'(underrun), 32'h1);

    // Capture and load on the same edge: old word loads, new word stays buffered.
    fetch_word(12'hA5C);
    flip = 1'b0;
    rom_data = 12'h123; fetch = 1'b1;
    step();
    fetch = 1'b0;
    do_load(1'b0);
    check("lit_same_ar", 32'(ar), 32'h5);
    check("lit_same_full", 32'(buf_full), 32'h1);
    flip = 1'b1;
    do_load(1'b0);
    check("lit_second_ar", 32'(ar), 32'h5);
    check("lit_second_full", 32'(buf_full), 32'h0);

    // Asynchronous reset mid-shift.
    fetch_word(12'hA5C);
    flip = 1'b0;
    do_load(1'b0);
    fetch_word(12'h3F0);
    check("lit_pre_reset_ar", 32'(ar), 32'h5);
    RESETn = 1'b0;
    #1;
    check("lit_async_ar", 32'(ar), 32'h0);
    check("lit_async_vld", 32'(pix_vld), 32'h0);
    check("lit_async_full", 32'(buf_full), 32'h0);
    check("lit_async_under", 32'(underrun), 32'h0);
    step(); step();
    RESETn = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ce_pix   = ($urandom_range(0, 9) < 7);
      ce_pic   = ($urandom_range(0, 1) == 1);
      pic_ld   = ($urandom_range(0, 3) == 0);
      sr_pic   = 8'($urandom_range(0, 255));
      addrlo   = 5'($urandom_range(0, 31));
      fetch    = ($urandom_range(0, 9) < 3);
      rom_data = 12'($urandom_range(0, 4095));
      matchn   = ($urandom_range(0, 4) == 0);
      mode     = 2'($urandom_range(0, 3));
      flip     = ($urandom_range(0, 1) == 1);
      if (i > 0 && (i % 997) == 0) begin
        RESETn = 1'b0;
        #1;
        RESETn = 1'b1;
      end
      step();
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
